// File: rtl/sound_request_ctrl_if.sv
// Request/finish handshake between the sound sequencer and the piezo tone player.
`timescale 1ns/1ps
interface sound_request_ctrl_if #(
    parameter int NOTE_W = 3
);
    logic              reque;
    logic [NOTE_W-1:0] note;
    logic              finish;

    modport master (output reque, output note, input finish);
    modport slave  (input reque, input note, output finish);
endinterface

// File: rtl/sound_request_ctrl.sv
// Queues sound events and issues one tone request at a time to the piezo player,
// with a silent gap between tones, request retries and sticky overflow/fault flags.
`timescale 1ns/1ps
module sound_request_ctrl #(
    parameter int QDEPTH      = 4,
    parameter int NOTE_W      = 3,
    parameter int GAP_CYCLES  = 1000000,
    parameter int ARM_TIMEOUT = 16,
    parameter int MAX_RETRY   = 3
) (
    input  logic                USER_CLK,
    input  logic                USER_RST_N,
    input  logic                event_valid,
    input  logic [NOTE_W-1:0]   event_note,
    output logic                event_ready,
    input  logic                clear_ovf,
    sound_request_ctrl_if.master player,
    output logic                busy,
    output logic                overflow,
    output logic                fault
);
    localparam int PTR_W   = $clog2(QDEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int T_MAX   = (GAP_CYCLES > ARM_TIMEOUT) ? GAP_CYCLES : ARM_TIMEOUT;
    localparam int TIMER_W = $clog2(T_MAX + 1);
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [TIMER_W-1:0] ARM_LAST  = TIMER_W'(ARM_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] GAP_LAST  = TIMER_W'(GAP_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_SAT = TIMER_W'(T_MAX);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_ARM, S_PLAY, S_GAP} state_t;

    state_t               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic [NOTE_W-1:0]    mem [QDEPTH];
    logic [PTR_W-1:0]     rd_ptr, wr_ptr;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 finish_meta, finish_sync;
    logic [NOTE_W-1:0]    note_q;
    logic                 reque_q, busy_q, overflow_q, fault_q;
    logic                 reque_d, busy_d, overflow_d, fault_d;
    logic                 push, pop, drop;

    assign event_ready = (count_q != CNT_W'(QDEPTH));
    assign push        = event_valid && event_ready;
    assign pop         = (state_q == S_IDLE) && (count_q != '0);

    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + CNT_W'(1);
        else if (!push && pop)
            count_d = count_q - CNT_W'(1);
    end

    // The player changes finish on the falling edge, so it is brought in through two flops.
    always_ff @(posedge USER_CLK or negedge USER_RST_N) begin
        if (!USER_RST_N) begin
            finish_meta <= 1'b1;
            finish_sync <= 1'b1;
        end else begin
            finish_meta <= player.finish;
            finish_sync <= finish_meta;
        end
    end

    always_ff @(posedge USER_CLK or negedge USER_RST_N) begin
        if (!USER_RST_N) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            retry_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            retry_q <= retry_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        retry_d = retry_q;
        drop    = 1'b0;
        case (state_q)
            S_IDLE: begin
                retry_d = '0;
                if (count_q != '0) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                timer_d = '0;
                state_d = S_ARM;
            end
            S_ARM: begin
                if (!finish_sync) begin
                    state_d = S_PLAY;
                end else if (timer_q == ARM_LAST) begin
                    if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + RETRY_W'(1);
                        state_d = S_ISSUE;
                    end else begin
                        drop    = 1'b1;
                        timer_d = '0;
                        state_d = S_GAP;
                    end
                end else if (timer_q != TIMER_SAT) begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            S_PLAY: begin
                if (finish_sync) begin
                    timer_d = '0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                // Holding GAP until the timer reaches GAP_CYCLES makes a zero gap last one cycle.
                if (timer_q >= GAP_LAST) state_d = S_IDLE;
                else                     timer_d = timer_q + TIMER_W'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        reque_d    = (state_d == S_ISSUE);
        busy_d     = (state_d != S_IDLE) || (count_d != '0);
        overflow_d = (event_valid && !event_ready) || (overflow_q && !clear_ovf);
        fault_d    = drop || (fault_q && !clear_ovf);
    end

    always_ff @(posedge USER_CLK or negedge USER_RST_N) begin
        if (!USER_RST_N) begin
            reque_q    <= 1'b0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            reque_q    <= reque_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
            fault_q    <= fault_d;
        end
    end

    always_ff @(posedge USER_CLK or negedge USER_RST_N) begin
        if (!USER_RST_N) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            note_q  <= '0;
        end else begin
            count_q <= count_d;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                note_q <= mem[rd_ptr];
            end
        end
    end

    // NOTE: queue storage has no reset; the count alone defines which entries are valid.
    always_ff @(posedge USER_CLK) begin
        if (push) mem[wr_ptr] <= event_note;
    end

    assign player.reque = reque_q;
    assign player.note  = note_q;
    assign busy         = busy_q;
    assign overflow     = overflow_q;
    assign fault        = fault_q;
endmodule

// File: tb/tb_sound_request_ctrl.sv
// Directed bench for sound_request_ctrl: a player model answers requests and a
// scoreboard queue holds the notes expected on each reque pulse.
`timescale 1ns/1ps
module tb_sound_request_ctrl;
    localparam int QDEPTH      = 4;
    localparam int NOTE_W      = 3;
    localparam int GAP_CYCLES  = 8;
    localparam int ARM_TIMEOUT = 4;
    localparam int MAX_RETRY   = 3;
    // reque at c: finish drops c+0.5, rises c+20.5, seen in PLAY at c+23 -> GAP,
    // GAP_CYCLES+2 later the next reque: c+33.
    localparam int PLAY_SPACING  = 23 + GAP_CYCLES + 2;
    localparam int RETRY_SPACING = ARM_TIMEOUT + 1;
    localparam int DROP_SPACING  = ARM_TIMEOUT + 1 + GAP_CYCLES + 2;

    logic              USER_CLK = 1'b0;
    logic              USER_RST_N = 1'b0;
    logic              event_valid = 1'b0;
    logic [NOTE_W-1:0] event_note = '0;
    logic              event_ready;
    logic              clear_ovf = 1'b0;
    logic              busy, overflow, fault;

    sound_request_ctrl_if #(.NOTE_W(NOTE_W)) ply_if ();

    sound_request_ctrl #(
        .QDEPTH(QDEPTH), .NOTE_W(NOTE_W), .GAP_CYCLES(GAP_CYCLES),
        .ARM_TIMEOUT(ARM_TIMEOUT), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .USER_CLK(USER_CLK), .USER_RST_N(USER_RST_N),
        .event_valid(event_valid), .event_note(event_note), .event_ready(event_ready),
        .clear_ovf(clear_ovf), .player(ply_if.master),
        .busy(busy), .overflow(overflow), .fault(fault)
    );

    always #5 USER_CLK = ~USER_CLK;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    logic [NOTE_W-1:0] exp_q[$];
    int req_cyc[$];
    logic dead_player = 1'b0;
    logic prev_reque = 1'b0;

    always @(posedge USER_CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Player: drops finish half a cycle after reque, raises it 20 cycles later.
    initial begin
        ply_if.finish = 1'b1;
        forever begin
            @(negedge USER_CLK);
            if (ply_if.reque && !dead_player) begin
                ply_if.finish = 1'b0;
                repeat (20) @(negedge USER_CLK);
                ply_if.finish = 1'b1;
            end
        end
    end

    // Scoreboard consumer: every reque pulse must carry the next expected note.
    always @(negedge USER_CLK) begin
        if (USER_RST_N && ply_if.reque) begin
            check("reque_not_back_to_back", prev_reque, 0);
            req_cyc.push_back(cyc);
            check("reque_has_expected_note", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check("note_order", ply_if.note, exp_q.pop_front());
        end
        prev_reque = ply_if.reque;
    end

    task automatic step();
        @(posedge USER_CLK);
        #1;
    endtask

    task automatic push_note(input logic [NOTE_W-1:0] n, input logic exp_ready);
        event_valid = 1'b1;
        event_note  = n;
        check("ready_before_push", event_ready, exp_ready);
        if (exp_ready) exp_q.push_back(n);
        step();
        event_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < budget) begin
            step();
            n++;
        end
        check(tag, n < budget, 1);
    endtask

    initial begin
        int c0;
        int n;

        // Reset state
        repeat (3) @(posedge USER_CLK);
        #1;
        check("rst_reque", ply_if.reque, 0);
        check("rst_note", ply_if.note, 0);
        check("rst_busy", busy, 0);
        check("rst_overflow", overflow, 0);
        check("rst_fault", fault, 0);
        check("rst_ready", event_ready, 1);
        USER_RST_N = 1'b1;
        repeat (3) step();

        // Single event: busy from the accept edge, reque exactly one cycle later
        req_cyc.delete();
        push_note(3'd5, 1'b1);
        check("single_busy_on_accept", busy, 1);
        check("single_no_reque_yet", ply_if.reque, 0);
        step();
        check("single_reque", ply_if.reque, 1);
        check("single_note", ply_if.note, 5);
        step();
        check("single_reque_drops", ply_if.reque, 0);
        check("single_note_held", ply_if.note, 5);
        wait_drain("single_drain", 200);
        check("single_busy_idle", busy, 0);
        check("single_reque_count", req_cyc.size(), 1);

        // Burst of six: five accepted, sixth refused, overflow sticky
        req_cyc.delete();
        for (int i = 1; i <= 5; i++) push_note(NOTE_W'(i), 1'b1);
        check("burst_full", event_ready, 0);
        push_note(3'd6, 1'b0);
        check("burst_overflow", overflow, 1);
        event_valid = 1'b1;
        event_note  = 3'd6;
        clear_ovf   = 1'b1;
        step();
        event_valid = 1'b0;
        clear_ovf   = 1'b0;
        check("clear_set_collision", overflow, 1);
        clear_ovf = 1'b1;
        step();
        clear_ovf = 1'b0;
        check("clear_ovf", overflow, 0);
        wait_drain("burst_drain", 600);
        check("burst_reque_count", req_cyc.size(), 5);
        if (req_cyc.size() >= 2)
            check("play_spacing", req_cyc[1] - req_cyc[0], PLAY_SPACING);

        // Dead player: 1+MAX_RETRY requests, fault, and a refused push on the pop edge
        req_cyc.delete();
        dead_player = 1'b1;
        push_note(3'd7, 1'b1);
        c0 = cyc + 1;
        for (int i = 0; i < MAX_RETRY; i++) exp_q.push_back(3'd7);
        push_note(3'd2, 1'b1);
        push_note(3'd3, 1'b1);
        push_note(3'd4, 1'b1);
        push_note(3'd5, 1'b1);
        n = 0;
        while (cyc < c0 + 4 * RETRY_SPACING + GAP_CYCLES + 1 && n < 200) begin
            if (cyc == c0 + 4 * RETRY_SPACING - 1) check("fault_not_early", fault, 0);
            step();
            n++;
        end
        check("dead_loop_bound", n < 200, 1);
        check("dead_fault", fault, 1);
        check("dead_full_before_pop", event_ready, 0);
        check("dead_reque_count", req_cyc.size(), 1 + MAX_RETRY);
        if (req_cyc.size() == 1 + MAX_RETRY)
            for (int i = 1; i <= MAX_RETRY; i++)
                check("retry_spacing", req_cyc[i] - req_cyc[i-1], RETRY_SPACING);
        event_valid = 1'b1;
        event_note  = 3'd6;
        step();
        event_valid = 1'b0;
        dead_player = 1'b0;
        check("full_pop_overflow", overflow, 1);
        check("full_pop_count3", event_ready, 1);
        check("after_gap_reque", ply_if.reque, 1);
        check("after_gap_note", ply_if.note, 2);
        push_note(3'd1, 1'b1);
        check("refill_full", event_ready, 0);
        wait_drain("dead_drain", 800);
        if (req_cyc.size() > 1 + MAX_RETRY)
            check("drop_to_next_spacing", req_cyc[1 + MAX_RETRY] - req_cyc[MAX_RETRY], DROP_SPACING);
        clear_ovf = 1'b1;
        step();
        clear_ovf = 1'b0;
        check("clear_fault", fault, 0);
        check("clear_overflow2", overflow, 0);

        // Reset mid-tone with two notes queued
        req_cyc.delete();
        push_note(3'd1, 1'b1);
        push_note(3'd2, 1'b1);
        push_note(3'd3, 1'b1);
        repeat (8) step();
        #2 USER_RST_N = 1'b0;
        #1;
        exp_q.delete();
        check("midrst_reque", ply_if.reque, 0);
        check("midrst_busy", busy, 0);
        check("midrst_note", ply_if.note, 0);
        check("midrst_ready", event_ready, 1);
        step();
        USER_RST_N = 1'b1;
        repeat (3) step();
        check("midrst_queue_flushed", busy, 0);
        n = 0;
        while (!ply_if.finish && n < 50) begin
            step();
            n++;
        end
        check("midrst_player_done", ply_if.finish, 1);
        push_note(3'd4, 1'b1);
        step();
        check("midrst_new_reque", ply_if.reque, 1);
        check("midrst_new_note", ply_if.note, 4);
        wait_drain("midrst_drain", 200);
        check("midrst_reque_count", req_cyc.size(), 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
